// File: rtl/dram_arbiter_rr_pkg.sv
// mem_pkg: shared constants for the DRAM arbiter slice.
//   CMD_READ / CMD_WRITE : encoding of the m_req_cmd / s_req_cmd bit.
//   mid_w()              : width of a master-ID tag, $clog2(N_MASTERS),
//                          clamped to at least one bit.
package mem_pkg;

  localparam logic CMD_READ  = 1'b1;
  localparam logic CMD_WRITE = 1'b0;

  function automatic int mid_w(input int n_masters);
    return (n_masters > 1) ? $clog2(n_masters) : 1;
  endfunction

endpackage

// File: rtl/dram_arbiter_rr_if.sv
// dram_arbiter_rr_if: bundle of the master-side and DRAM-side buses around
// the round-robin DRAM arbiter.
//   m_req_* : N_MASTERS request channels (en/rdy/cmd, packed addr/data)
//   m_rsp_* : N_MASTERS response channels, one shared data bus
//   s_req_* : single forwarded request channel towards DRAM
//   s_rsp_* : single response channel from DRAM
// Handshake rule for every *_en/*_rdy pair: a beat transfers on the rising
// clock edge where en and rdy are both 1; once en is raised the sender keeps
// en and the payload stable until that edge, and rdy may depend
// combinationally on en.
// Modports:
//   slave  : the arbiter (accepts master requests, drives the DRAM side)
//   master : the environment (masters and DRAM model driving the arbiter)
interface dram_arbiter_rr_if #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) ();

  logic [N_MASTERS-1:0]        m_req_en;
  logic [N_MASTERS-1:0]        m_req_rdy;
  logic [N_MASTERS-1:0]        m_req_cmd;
  logic [N_MASTERS*ADDR_W-1:0] m_req_addr;
  logic [N_MASTERS*DATA_W-1:0] m_req_data;
  logic [N_MASTERS-1:0]        m_rsp_en;
  logic [N_MASTERS-1:0]        m_rsp_rdy;
  logic [DATA_W-1:0]           m_rsp_data;

  logic                        s_req_en;
  logic                        s_req_rdy;
  logic                        s_req_cmd;
  logic [ADDR_W-1:0]           s_req_addr;
  logic [DATA_W-1:0]           s_req_data;
  logic                        s_rsp_en;
  logic                        s_rsp_rdy;
  logic [DATA_W-1:0]           s_rsp_data;

  modport slave (
    input  m_req_en, m_req_cmd, m_req_addr, m_req_data, m_rsp_rdy,
    input  s_req_rdy, s_rsp_en, s_rsp_data,
    output m_req_rdy, m_rsp_en, m_rsp_data,
    output s_req_en, s_req_cmd, s_req_addr, s_req_data, s_rsp_rdy
  );

  modport master (
    output m_req_en, m_req_cmd, m_req_addr, m_req_data, m_rsp_rdy,
    output s_req_rdy, s_rsp_en, s_rsp_data,
    input  m_req_rdy, m_rsp_en, m_rsp_data,
    input  s_req_en, s_req_cmd, s_req_addr, s_req_data, s_rsp_rdy
  );

endinterface

// File: rtl/dram_arbiter_rr_tag_fifo.sv
// tag_fifo: read-tag FIFO of the DRAM arbiter. Holds the master ID of every
// read sent to DRAM so responses can be routed back in order.
// Ports:
//   clk, rstn      : clock, asynchronous active-low reset
//   push_i, din_i  : write a tag (ignored when full)
//   pop_i          : drop the head tag (ignored when empty)
//   dout_o         : head tag, valid while empty_o is 0
//   full_o/empty_o : status, derived from the registered count
//   count_o        : tags currently held (pushes minus pops)
module tag_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/dram_arbiter_rr.sv
// dram_arbiter_rr: round-robin arbiter sharing one DRAM port between
// N_MASTERS requesters (0 = icache, 1 = dcache, ...), with in-order routing
// of read responses through a tag FIFO.
// Ports:
//   clk, rstn      : clock, asynchronous active-low reset
//   bus            : dram_arbiter_rr_if.slave (master and DRAM channels)
//   rd_outstanding : reads sent to DRAM and not yet answered
//   err_unexp_rsp  : sticky, DRAM answered while no read was outstanding
module dram_arbiter_rr
  import mem_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RD_DEPTH  = 32
) (
  input  logic                          clk,
  input  logic                          rstn,
  dram_arbiter_rr_if.slave              bus,
  output logic [$clog2(RD_DEPTH+1)-1:0] rd_outstanding,
  output logic                          err_unexp_rsp
);

  localparam int MID_W = mid_w(N_MASTERS);
  localparam int CNT_W = $clog2(RD_DEPTH+1);

  logic [MID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [MID_W-1:0]     gnt_q, gnt_d;
  logic                 lock_q, lock_d;
  logic                 err_q, err_d;

  logic                 found;
  logic [MID_W-1:0]     sel;
  logic                 sel_cmd;
  logic                 req_en;
  logic                 xfer;
  logic [N_MASTERS-1:0] req_rdy;

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [MID_W-1:0]     head;
  logic [CNT_W-1:0]     fifo_count;
  logic                 rsp_live;
  logic                 rsp_rdy;
  logic [N_MASTERS-1:0] rsp_en;

  // Grant selection. A grant that was presented but not taken (DRAM not
  // ready, or a read waiting for a free tag) stays locked, so the forwarded
  // request never changes under a pending handshake and a blocked read is
  // not overtaken by another master.
  always_comb begin
    found = 1'b0;
    sel   = rr_ptr_q;
    if (lock_q && bus.m_req_en[gnt_q]) begin
      found = 1'b1;
      sel   = gnt_q;
    end else begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (!found && bus.m_req_en[(int'(rr_ptr_q) + i) % N_MASTERS]) begin
          found = 1'b1;
          sel   = MID_W'((int'(rr_ptr_q) + i) % N_MASTERS);
        end
      end
    end
  end

  // Full is taken from the registered count, so a pop in the same cycle
  // does not unblock a read; this also keeps s_rsp_* out of the s_req_* path.
  assign sel_cmd = bus.m_req_cmd[sel];
  assign req_en  = rstn & found & ~((sel_cmd == CMD_READ) & fifo_full);
  assign xfer    = req_en & bus.s_req_rdy;

  always_comb begin
    req_rdy      = '0;
    req_rdy[sel] = xfer;
  end

  assign bus.s_req_en   = req_en;
  assign bus.s_req_cmd  = sel_cmd;
  assign bus.s_req_addr = bus.m_req_addr[int'(sel)*ADDR_W +: ADDR_W];
  assign bus.s_req_data = bus.m_req_data[int'(sel)*DATA_W +: DATA_W];
  assign bus.m_req_rdy  = req_rdy;

  // Next-state for the arbitration registers.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    gnt_d    = sel;
    lock_d   = found & ~xfer;
    if (xfer) begin
      rr_ptr_d = (sel == MID_W'(N_MASTERS-1)) ? '0 : sel + MID_W'(1);
    end
  end

  // Response routing follows the FIFO head combinationally.
  assign rsp_live = rstn & ~fifo_empty;
  assign rsp_rdy  = rsp_live & bus.m_rsp_rdy[head];

  always_comb begin
    rsp_en       = '0;
    rsp_en[head] = rsp_live & bus.s_rsp_en;
  end

  assign bus.m_rsp_en   = rsp_en;
  assign bus.m_rsp_data = bus.s_rsp_data;
  assign bus.s_rsp_rdy  = rsp_rdy;

  assign fifo_push = xfer & (sel_cmd == CMD_READ);
  assign fifo_pop  = bus.s_rsp_en & rsp_rdy;

  assign err_d = err_q | (bus.s_rsp_en & fifo_empty);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      lock_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      lock_q   <= lock_d;
      err_q    <= err_d;
    end
  end

  tag_fifo #(
    .WIDTH (MID_W),
    .DEPTH (RD_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (fifo_push),
    .din_i   (sel),
    .pop_i   (fifo_pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign rd_outstanding = fifo_count;
  assign err_unexp_rsp  = err_q;

endmodule

// File: tb/tb_dram_arbiter_rr.sv
module tb_dram_arbiter_rr;

  localparam int N     = 4;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int MW    = 2;
  localparam int CW    = 3;
  localparam int REQ_W = MW + 1 + AW + DW;
  localparam int RSP_W = MW + DW;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  dram_arbiter_rr_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
  logic [CW-1:0] rd_outstanding;
  logic          err_unexp_rsp;

  dram_arbiter_rr #(
    .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .RD_DEPTH(DEPTH)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .bus            (bus),
    .rd_outstanding (rd_outstanding),
    .err_unexp_rsp  (err_unexp_rsp)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [REQ_W-1:0] exp_req_q[$];
  logic [RSP_W-1:0] exp_rsp_q[$];

  // Reference model: a round-robin pointer, the master whose request is
  // being held, the list of outstanding read owners and the sticky error.
  int tag_q[$];
  int m_ptr  = 0;
  int m_hold = -1;
  bit m_err  = 1'b0;

  // Per-cycle expectations published by the model for the monitor.
  logic          exp_sreq_en  = 1'b0;
  logic          exp_srsp_rdy = 1'b0;
  logic [AW-1:0] exp_addr     = '0;
  logic [N-1:0]  exp_rsp_mask = '0;
  int            exp_cnt      = 0;
  bit            exp_err      = 1'b0;

  // Master / DRAM driver state.
  logic [N-1:0]  pend     = '0;
  logic [N-1:0]  acc_seen = '0;
  logic [AW-1:0] p_addr [N];
  logic [DW-1:0] p_data [N];
  logic          p_cmd  [N];
  logic [N-1:0]  gen_mask      = '0;
  int            gen_pct       = 0;
  int            cmd_mode      = 1;  // 0 random, 1 read, 2 write
  int            sreq_rdy_mode = 1;  // 0 low, 1 high, 2 random
  int            rsp_mode      = 0;  // 0 off, 1 random if owed, 2 forced on, 3 on if owed
  int            mrsp_rdy_mode = 1;  // 1 all ready, 2 random

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [MW-1:0] idx_of(input logic [N-1:0] v);
    logic [MW-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = MW'(i);
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply();
    for (int i = 0; i < N; i++) begin
      bus.m_req_en[i]              = pend[i];
      bus.m_req_cmd[i]             = p_cmd[i];
      bus.m_req_addr[i*AW +: AW]   = p_addr[i];
      bus.m_req_data[i*DW +: DW]   = p_data[i];
    end
  endtask

  task automatic post(input int m, input logic cmd);
    if (!pend[m]) begin
      pend[m]   = 1'b1;
      p_cmd[m]  = cmd;
      p_addr[m] = AW'($urandom);
      p_data[m] = DW'($urandom);
      apply();
    end
  endtask

  task automatic cycle();
    logic c;
    @(posedge clk);
    #1;
    pend = pend & ~acc_seen;
    for (int i = 0; i < N; i++) begin
      if (gen_mask[i] && int'($urandom_range(0, 99)) < gen_pct) begin
        c = (cmd_mode == 0) ? 1'($urandom_range(0, 1)) : (cmd_mode == 1);
        post(i, c);
      end
    end
    apply();
    case (sreq_rdy_mode)
      0:       bus.s_req_rdy = 1'b0;
      1:       bus.s_req_rdy = 1'b1;
      default: bus.s_req_rdy = 1'($urandom_range(0, 1));
    endcase
    case (rsp_mode)
      1:       bus.s_rsp_en = (tag_q.size() > 0) && ($urandom_range(0, 1) == 1);
      2:       bus.s_rsp_en = 1'b1;
      3:       bus.s_rsp_en = (tag_q.size() > 0);
      default: bus.s_rsp_en = 1'b0;
    endcase
    bus.s_rsp_data = DW'($urandom);
    bus.m_rsp_rdy  = (mrsp_rdy_mode == 1) ? '1 : N'($urandom);
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0;
    repeat (n) cycle();
    rstn = 1'b1;
  endtask

  // ---------------- reference model ----------------
  task automatic model_step();
    int            g;
    int            head;
    bit            full, en, xfer, cmd;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (!rstn) begin
      m_ptr = 0; m_hold = -1; m_err = 1'b0;
      tag_q.delete(); exp_req_q.delete(); exp_rsp_q.delete();
      exp_sreq_en = 1'b0; exp_srsp_rdy = 1'b0; exp_rsp_mask = '0;
      exp_cnt = 0; exp_err = 1'b0;
      return;
    end
    g = -1;
    if (m_hold >= 0 && bus.m_req_en[m_hold]) g = m_hold;
    else begin
      for (int k = 0; k < N; k++)
        if (g < 0 && bus.m_req_en[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    cmd = 1'b0; a = '0; d = '0;
    if (g >= 0) begin
      cmd = bus.m_req_cmd[g];
      a   = bus.m_req_addr[g*AW +: AW];
      d   = bus.m_req_data[g*DW +: DW];
    end
    full        = (tag_q.size() == DEPTH);
    en          = (g >= 0) && !(cmd && full);
    xfer        = en && bus.s_req_rdy;
    exp_sreq_en = en;
    exp_addr    = a;
    exp_cnt     = tag_q.size();
    exp_err     = m_err;
    if (tag_q.size() > 0) begin
      head         = tag_q[0];
      exp_rsp_mask = bus.s_rsp_en ? (N'(1) << head) : '0;
      exp_srsp_rdy = bus.m_rsp_rdy[head];
      if (bus.s_rsp_en && bus.m_rsp_rdy[head]) begin
        exp_rsp_q.push_back({MW'(head), bus.s_rsp_data});
        void'(tag_q.pop_front());
      end
    end else begin
      exp_rsp_mask = '0;
      exp_srsp_rdy = 1'b0;
      if (bus.s_rsp_en) m_err = 1'b1;
    end
    if (xfer) begin
      exp_req_q.push_back({MW'(g), cmd, a, d});
      if (cmd) tag_q.push_back(g);
      m_ptr  = (g + 1) % N;
      m_hold = -1;
    end else begin
      m_hold = g;
    end
  endtask

  always @(posedge clk) begin
    #2;
    model_step();
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [REQ_W-1:0] got_req;
    logic [RSP_W-1:0] got_rsp;
    if (!rstn) begin
      check("rst_en_rdy", 64'({bus.m_req_rdy, bus.m_rsp_en, bus.s_req_en, bus.s_rsp_rdy}), 64'(0));
      check("rst_outstanding", 64'(rd_outstanding), 64'(0));
      check("rst_err", 64'(err_unexp_rsp), 64'(0));
      acc_seen = '0;
    end else begin
      check("s_req_en", 64'(bus.s_req_en), 64'(exp_sreq_en));
      if (exp_sreq_en) check("s_req_addr", 64'(bus.s_req_addr), 64'(exp_addr));
      check("m_rsp_en", 64'(bus.m_rsp_en), 64'(exp_rsp_mask));
      check("s_rsp_rdy", 64'(bus.s_rsp_rdy), 64'(exp_srsp_rdy));
      check("rd_outstanding", 64'(rd_outstanding), 64'(exp_cnt));
      check("err_unexp_rsp", 64'(err_unexp_rsp), 64'(exp_err));

      if (bus.s_req_en && bus.s_req_rdy) begin
        got_req = {idx_of(bus.m_req_rdy), bus.s_req_cmd, bus.s_req_addr, bus.s_req_data};
        check("m_req_rdy_onehot", 64'($onehot(bus.m_req_rdy)), 64'(1));
        if (exp_req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL req_xfer: got %0h expected no transfer at %0t", got_req, $time);
        end else begin
          check("req_xfer", 64'(got_req), 64'(exp_req_q.pop_front()));
        end
        acc_seen = bus.m_req_rdy;
      end else begin
        acc_seen = '0;
        if (exp_req_q.size() > 0) begin
          checks++; errors++;
          $display("FAIL req_xfer: got none expected %0h at %0t", exp_req_q.pop_front(), $time);
        end
      end

      if (bus.s_rsp_en && bus.s_rsp_rdy) begin
        got_rsp = {idx_of(bus.m_rsp_en), bus.m_rsp_data};
        if (exp_rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_route: got %0h expected no response at %0t", got_rsp, $time);
        end else begin
          check("rsp_route", 64'(got_rsp), 64'(exp_rsp_q.pop_front()));
        end
      end else if (exp_rsp_q.size() > 0) begin
        checks++; errors++;
        $display("FAIL rsp_route: got none expected %0h at %0t", exp_rsp_q.pop_front(), $time);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.m_req_en = '0; bus.m_req_cmd = '0; bus.m_req_addr = '0; bus.m_req_data = '0;
    bus.m_rsp_rdy = '0; bus.s_req_rdy = 1'b0; bus.s_rsp_en = 1'b0; bus.s_rsp_data = '0;
    for (int i = 0; i < N; i++) begin
      p_addr[i] = '0; p_data[i] = '0; p_cmd[i] = 1'b0;
    end
    do_reset(3);

    // Two masters streaming reads, DRAM always ready: grants alternate.
    gen_mask = 4'b0011; gen_pct = 100; cmd_mode = 1;
    sreq_rdy_mode = 1; rsp_mode = 3; mrsp_rdy_mode = 1;
    repeat (30) cycle();
    gen_mask = '0;
    repeat (10) cycle();

    // Pointer moved to 2 by a master-1 read, then masters 1 and 3 compete,
    // master 0 joins one cycle later.
    rsp_mode = 0;
    do_reset(2);
    post(1, 1'b1);
    cycle();
    cycle();
    post(1, 1'b1); post(3, 1'b1);
    cycle();
    post(0, 1'b1);
    repeat (4) cycle();
    rsp_mode = 3;
    repeat (8) cycle();

    // Tag FIFO fills with master-0 reads; a master-1 write waits behind the
    // blocked read until one response pops.
    rsp_mode = 0;
    do_reset(2);
    gen_mask = 4'b0001; gen_pct = 100; cmd_mode = 1;
    repeat (8) cycle();
    post(1, 1'b0);
    repeat (4) cycle();
    rsp_mode = 3;
    cycle();
    rsp_mode = 0; gen_mask = '0;
    repeat (4) cycle();
    rsp_mode = 3;
    repeat (10) cycle();

    // DRAM stalls with master 0 granted and master 1 waiting.
    do_reset(2);
    sreq_rdy_mode = 0; rsp_mode = 0;
    post(0, 1'b1); post(1, 1'b1);
    repeat (3) cycle();
    sreq_rdy_mode = 1;
    repeat (4) cycle();
    rsp_mode = 3;
    repeat (6) cycle();

    // Response with nothing outstanding raises the sticky error.
    do_reset(2);
    rsp_mode = 2;
    cycle();
    rsp_mode = 0;
    post(2, 1'b1);
    repeat (5) cycle();

    // Reset with three reads outstanding and a DRAM response in flight.
    do_reset(2);
    gen_mask = 4'b0011; gen_pct = 100; cmd_mode = 1; rsp_mode = 0;
    repeat (3) cycle();
    gen_mask = '0;
    cycle();
    rsp_mode = 2;
    rstn = 1'b0;
    repeat (2) cycle();
    post(0, 1'b1); post(1, 1'b1);
    rstn = 1'b1;
    cycle();
    rsp_mode = 3;
    repeat (8) cycle();

    // Randomized traffic on all masters.
    do_reset(2);
    gen_mask = '1; gen_pct = 40; cmd_mode = 0;
    sreq_rdy_mode = 2; rsp_mode = 1; mrsp_rdy_mode = 2;
    repeat (600) cycle();
    gen_mask = '0; sreq_rdy_mode = 1; rsp_mode = 3; mrsp_rdy_mode = 1;
    repeat (20) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
